// File: rtl/retospect_bs_loader_if.sv
// Byte-stream handshake between the configuration host and the bitstream loader.
// The host side drives data/valid; the loader side answers with ready.
interface retospect_bs_loader_if;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;

   modport master (
      output byte_data,
      output byte_valid,
      input  byte_ready
   );

   modport slave (
      input  byte_data,
      input  byte_valid,
      output byte_ready
   );
endinterface

// File: rtl/retospect_bs_loader.sv
// Serializes host configuration bytes LSB-first into the neurochip chain, pulses reset_nn,
// and keeps a CRC-16-CCITT of the bits pushed out of the chain tail.
module retospect_bs_loader #(
   parameter int unsigned CHAIN_LEN     = 523,
   parameter int unsigned RST_NN_CYCLES = 2,
   parameter int unsigned CNT_W         = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
   retospect_bs_loader_if.slave        bus,
   input  logic                        bs_out_fb,
   output logic                        config_en,
   output logic                        bs_in,
   output logic                        reset_nn,
   output logic                        busy,
   output logic                        done,
   output logic [15:0]                 crc_prev
);

   localparam int unsigned      RW       = (RST_NN_CYCLES > 1) ? $clog2(RST_NN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
   localparam logic [RW-1:0]    RST_LAST = RW'(RST_NN_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StWaitByte, StShift, StNnRst, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, cnt_inc;
   logic [7:0]       shreg_q, shreg_d;
   logic [3:0]       nbits_q, nbits_d;
   logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
   logic [15:0]      crc_q, crc_d, crc_prev_q, crc_prev_d;
   logic             config_en_q, bs_in_q, reset_nn_q, done_q;
   logic             byte_ready;

   // Bits still owed to the chain, capped at one byte; the tail byte is truncated here.
   function automatic logic [3:0] nbits_for(input logic [CNT_W-1:0] cnt);
      logic [CNT_W-1:0] rem;
      rem = LEN_C - cnt;
      return (rem >= CNT_W'(8)) ? 4'd8 : rem[3:0];
   endfunction

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   assign cnt_inc = bit_cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      nbits_d    = nbits_q;
      rst_cnt_d  = rst_cnt_q;
      crc_d      = crc_q;
      crc_prev_d = crc_prev_q;
      byte_ready = 1'b0;
      if (abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_d   = StWaitByte;
                  bit_cnt_d = '0;
                  crc_d     = 16'hFFFF;
               end
            end
            StWaitByte: begin
               byte_ready = 1'b1;
               if (bus.byte_valid) begin
                  shreg_d = bus.byte_data;
                  nbits_d = nbits_for(bit_cnt_q);
                  state_d = StShift;
               end
            end
            StShift: begin
               shreg_d   = shreg_q >> 1;
               nbits_d   = nbits_q - 4'd1;
               bit_cnt_d = cnt_inc;
               crc_d     = crc_step(crc_q, bs_out_fb);
               if (cnt_inc == LEN_C) begin
                  state_d   = StNnRst;
                  rst_cnt_d = '0;
               end else if (nbits_q == 4'd1) begin
                  // Accepting the next byte on the last bit keeps the chain shifting gap-free.
                  byte_ready = 1'b1;
                  if (bus.byte_valid) begin
                     shreg_d = bus.byte_data;
                     nbits_d = nbits_for(cnt_inc);
                  end else begin
                     state_d = StWaitByte;
                  end
               end
            end
            StNnRst: begin
               if (rst_cnt_q == RST_LAST) begin
                  state_d    = StDone;
                  crc_prev_d = crc_q;
               end else begin
                  rst_cnt_d = rst_cnt_q + RW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         nbits_q     <= '0;
         rst_cnt_q   <= '0;
         crc_q       <= 16'hFFFF;
         crc_prev_q  <= 16'hFFFF;
         config_en_q <= 1'b0;
         bs_in_q     <= 1'b0;
         reset_nn_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         nbits_q     <= nbits_d;
         rst_cnt_q   <= rst_cnt_d;
         crc_q       <= crc_d;
         crc_prev_q  <= crc_prev_d;
         // Outputs are registered from the next state so they line up with state_q.
         config_en_q <= (state_d == StShift);
         bs_in_q     <= (state_d == StShift) & shreg_d[0];
         reset_nn_q  <= (state_d == StNnRst);
         done_q      <= (state_d == StDone);
      end
   end

   assign bus.byte_ready = byte_ready;
   assign config_en      = config_en_q;
   assign bs_in          = bs_in_q;
   assign reset_nn       = reset_nn_q;
   assign done           = done_q;
   assign crc_prev       = crc_prev_q;
   assign busy           = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Bench for retospect_bs_loader: models the 523-bit chain, checks the shifted stream, the
// reset_nn pulse and the CRC of displaced bits against a queue-based reference.
module tb_retospect_bs_loader;
   localparam int unsigned CHAIN_LEN     = 523;
   localparam int unsigned RST_NN_CYCLES = 2;
   localparam int unsigned CNT_W         = 10;
   localparam int unsigned NBYTES        = (CHAIN_LEN + 7) / 8;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, bs_out_fb;
   logic        config_en, bs_in, reset_nn, busy, done;
   logic [15:0] crc_prev;

   retospect_bs_loader_if bus ();

   retospect_bs_loader #(
      .CHAIN_LEN    (CHAIN_LEN),
      .RST_NN_CYCLES(RST_NN_CYCLES),
      .CNT_W        (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .bus      (bus.slave),
      .bs_out_fb(bs_out_fb),
      .config_en(config_en),
      .bs_in    (bs_in),
      .reset_nn (reset_nn),
      .busy     (busy),
      .done     (done),
      .crc_prev (crc_prev)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Chain model: shifts on config_en, tail feeds bs_out_fb.
   logic [CHAIN_LEN-1:0] chain, chain_seed, prev_chain;
   logic                 chain_init;
   always @(posedge clk) begin
      if (chain_init) chain <= chain_seed;
      else if (config_en) chain <= {chain[CHAIN_LEN-2:0], bs_in};
   end
   assign bs_out_fb = chain[CHAIN_LEN-1];

   // Monitor
   bit got_bits[$];
   int cur_run, max_run, nn_cnt, overlap;
   always @(negedge clk) begin
      if (config_en) begin
         got_bits.push_back(bs_in);
         cur_run++;
         if (cur_run > max_run) max_run = cur_run;
      end else begin
         cur_run = 0;
      end
      if (reset_nn) nn_cnt++;
      if (config_en && reset_nn) overlap++;
   end

   function automatic logic [15:0] crc16_bits(input bit q[$]);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (q[i]) begin
         if (c[15] ^ q[i]) c = (c << 1) ^ 16'h1021;
         else c = c << 1;
      end
      return c;
   endfunction

   function automatic logic [15:0] crc_of_chain(input logic [CHAIN_LEN-1:0] v);
      bit q[$];
      for (int i = CHAIN_LEN - 1; i >= 0; i--) q.push_back(v[i]);
      return crc16_bits(q);
   endfunction

   logic [7:0] tx [NBYTES];

   task automatic clear_mon();
      got_bits.delete();
      cur_run = 0;
      max_run = 0;
      nn_cnt  = 0;
      overlap = 0;
   endtask

   // mode 0: valid always, 1: valid every 3rd cycle, 2: random valid
   task automatic run_load(input string name, input int mode, input bit poke_start);
      int  idx, cyc, bad;
      bit  offer, finished;
      prev_chain = chain;
      clear_mon();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      idx = 0; cyc = 0; finished = 0;
      while (!finished && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         start = poke_start && (cyc == 40 || cyc == 300);
         offer = (idx < NBYTES) && (mode == 0 || (mode == 1 && cyc % 3 == 0) ||
                                    (mode == 2 && $urandom_range(9) < 6));
         bus.byte_valid = offer;
         bus.byte_data  = offer ? tx[idx] : 8'($urandom);
         #4;
         if (offer && bus.byte_ready) idx++;
         if (done) finished = 1;
      end
      bus.byte_valid = 1'b0;
      start = 1'b0;
      check({name, " done_seen"}, 32'(finished), 32'd1);
      check({name, " bytes_used"}, 32'(idx), 32'(NBYTES));
      check({name, " en_cycles"}, 32'(got_bits.size()), 32'(CHAIN_LEN));
      bad = 0;
      for (int k = 0; k < CHAIN_LEN; k++) begin
         if (k >= got_bits.size() || got_bits[k] !== tx[k / 8][k % 8]) bad++;
      end
      check({name, " bit_stream_errs"}, 32'(bad), 32'd0);
      check({name, " reset_nn_cycles"}, 32'(nn_cnt), 32'(RST_NN_CYCLES));
      check({name, " en_nn_overlap"}, 32'(overlap), 32'd0);
      check({name, " crc_prev"}, 32'(crc_prev), 32'(crc_of_chain(prev_chain)));
      check({name, " busy_after"}, 32'(busy), 32'd0);
      if (mode == 0) check({name, " en_run"}, 32'(max_run), 32'(CHAIN_LEN));
      if (mode == 1) check({name, " gaps_present"}, 32'(max_run < CHAIN_LEN), 32'd1);
   endtask

   // Starts a load and streams bytes until nbits bits have gone out.
   task automatic partial_load(input int nbits);
      int idx, cyc;
      clear_mon();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      idx = 0; cyc = 0;
      while (got_bits.size() < nbits && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         bus.byte_valid = 1'b1;
         bus.byte_data  = tx[idx];
         #4;
         if (bus.byte_ready) idx++;
      end
      check("partial_reached", 32'(got_bits.size() >= nbits), 32'd1);
   endtask

   typedef struct {
      logic start;
      logic abort;
      logic exp_busy;
      logic exp_ready;
   } ctl_vec_t;
   ctl_vec_t vecs[6];

   initial begin
      logic [15:0] crc_before;
      bit          zeros[$];

      vecs[0] = '{start: 1'b0, abort: 1'b0, exp_busy: 1'b0, exp_ready: 1'b0};
      vecs[1] = '{start: 1'b1, abort: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
      vecs[2] = '{start: 1'b1, abort: 1'b0, exp_busy: 1'b1, exp_ready: 1'b1};
      vecs[3] = '{start: 1'b1, abort: 1'b0, exp_busy: 1'b1, exp_ready: 1'b1};
      vecs[4] = '{start: 1'b0, abort: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
      vecs[5] = '{start: 1'b0, abort: 1'b0, exp_busy: 1'b0, exp_ready: 1'b0};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
      for (int i = 0; i < CHAIN_LEN; i++) chain_seed[i] = 1'($urandom);
      chain_init = 1'b1;
      repeat (3) @(posedge clk);
      #1 chain_init = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      #1;
      check("rst config_en", 32'(config_en), 32'd0);
      check("rst reset_nn", 32'(reset_nn), 32'd0);
      check("rst busy_done", 32'({busy, done}), 32'd0);
      check("rst byte_ready", 32'(bus.byte_ready), 32'd0);
      check("rst crc_prev", 32'(crc_prev), 32'hFFFF);

      foreach (vecs[i]) begin
         @(negedge clk);
         start = vecs[i].start;
         abort = vecs[i].abort;
         @(posedge clk); #1;
         start = 1'b0; abort = 1'b0;
         #1;
         check($sformatf("ctl[%0d] busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         check($sformatf("ctl[%0d] ready", i), 32'(bus.byte_ready), 32'(vecs[i].exp_ready));
      end

      foreach (tx[i]) tx[i] = 8'hA5;
      run_load("full_a5", 0, 0);
      run_load("throttled_a5", 1, 0);

      // start in DONE begins a new load, done drops next cycle
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("restart done", 32'(done), 32'd0);
      check("restart busy", 32'(busy), 32'd1);
      @(negedge clk); abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      check("abort_wait busy", 32'(busy), 32'd0);

      foreach (tx[i]) tx[i] = 8'h00;
      run_load("load_zeros", 0, 0);
      foreach (tx[i]) tx[i] = 8'hFF;
      run_load("load_ones", 2, 0);
      for (int i = 0; i < CHAIN_LEN; i++) zeros.push_back(1'b0);
      check("loopback crc", 32'(crc_prev), 32'(crc16_bits(zeros)));

      // Abort after 100 bits
      foreach (tx[i]) tx[i] = 8'($urandom);
      crc_before = crc_prev;
      partial_load(100);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      bus.byte_valid = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort config_en", 32'(config_en), 32'd0);
      check("abort byte_ready", 32'(bus.byte_ready), 32'd0);
      check("abort crc_prev", 32'(crc_prev), 32'(crc_before));
      repeat (10) @(posedge clk);
      #1 check("abort no reset_nn", 32'(nn_cnt), 32'd0);
      run_load("after_abort", 0, 0);

      for (int r = 0; r < 3; r++) begin
         foreach (tx[i]) tx[i] = 8'($urandom);
         run_load($sformatf("rand%0d", r), 2, r == 1);
      end

      // Asynchronous reset mid-SHIFT
      partial_load(50);
      bus.byte_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst config_en", 32'(config_en), 32'd0);
      check("async_rst busy", 32'(busy), 32'd0);
      check("async_rst crc_prev", 32'(crc_prev), 32'hFFFF);
      repeat (4) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("async_rst no reset_nn", 32'(nn_cnt), 32'd0);
      foreach (tx[i]) tx[i] = 8'($urandom);
      run_load("after_reset", 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
